// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage : ID->EX register with forwarding, 2-bit ALU decode, backpressure
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm16,
  input  logic [REG_AW-1:0] rs_idx,
  input  logic [REG_AW-1:0] rt_idx,
  input  logic [REG_AW-1:0] rd_idx,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              fwd1_we,
  input  logic [REG_AW-1:0] fwd1_rd,
  input  logic [DATA_W-1:0] fwd1_data,
  input  logic              fwd2_we,
  input  logic [REG_AW-1:0] fwd2_rd,
  input  logic [DATA_W-1:0] fwd2_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        ALUCtl_2,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] store_data,
  output logic [REG_AW-1:0] dst_idx,
  output logic              reg_we,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRA   = 6'h03;

  logic [DATA_W-1:0] val_rs, val_rt, sext, zsh;
  logic [DATA_W-1:0] d_a, d_b;
  logic [REG_AW-1:0] d_dst;
  logic [1:0]        d_ctl;
  logic              d_we, d_mrd, d_mwr, d_ill;

  assign in_ready = !out_valid || out_ready;
  assign sext     = {{(DATA_W-16){imm16[15]}}, imm16};
  assign zsh      = {{(DATA_W-5){1'b0}}, shamt};

  // EX/MEM is younger than MEM/WB, so it wins when both target the same register
  always_comb begin
    val_rs = rs_data;
    if (rs_idx == '0)                          val_rs = '0;
    else if (fwd1_we && (fwd1_rd == rs_idx))   val_rs = fwd1_data;
    else if (fwd2_we && (fwd2_rd == rs_idx))   val_rs = fwd2_data;

    val_rt = rt_data;
    if (rt_idx == '0)                          val_rt = '0;
    else if (fwd1_we && (fwd1_rd == rt_idx))   val_rt = fwd1_data;
    else if (fwd2_we && (fwd2_rd == rt_idx))   val_rt = fwd2_data;
  end

  always_comb begin
    d_ctl = 2'd0;
    d_a   = val_rs;
    d_b   = val_rt;
    d_dst = '0;
    d_we  = 1'b0;
    d_mrd = 1'b0;
    d_mwr = 1'b0;
    d_ill = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        d_dst = rd_idx;
        d_we  = 1'b1;
        case (funct)
          FN_ADD: d_ctl = 2'd0;
          FN_SUB: d_ctl = 2'd1;
          FN_SLL: begin d_ctl = 2'd2; d_a = val_rt; d_b = zsh; end
          FN_SRA: begin d_ctl = 2'd3; d_a = val_rt; d_b = zsh; end
          default: begin d_ill = 1'b1; d_we = 1'b0; d_dst = '0; end
        endcase
      end
      OP_ADDI: begin d_b = sext; d_dst = rt_idx; d_we = 1'b1; end
      OP_LW:   begin d_b = sext; d_dst = rt_idx; d_we = 1'b1; d_mrd = 1'b1; end
      OP_SW:   begin d_b = sext; d_mwr = 1'b1; end
      OP_BEQ:  d_ctl = 2'd1;
      default: d_ill = 1'b1;
    endcase
    if (d_dst == '0) d_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      ALUCtl_2   <= 2'd0;
      alu_a      <= '0;
      alu_b      <= '0;
      store_data <= '0;
      dst_idx    <= '0;
      reg_we     <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      illegal    <= 1'b0;
    end else if (flush) begin
      // operand registers are left as-is; only the side-effecting controls die
      out_valid <= 1'b0;
      reg_we    <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      illegal   <= 1'b0;
    end else if (in_ready) begin
      if (in_valid) begin
        out_valid  <= 1'b1;
        ALUCtl_2   <= d_ctl;
        alu_a      <= d_a;
        alu_b      <= d_b;
        store_data <= val_rt;
        dst_idx    <= d_dst;
        reg_we     <= d_we;
        mem_rd     <= d_mrd;
        mem_wr     <= d_mwr;
        illegal    <= d_ill;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage : directed + random check of id_ex_stage against a reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [5:0]  opcode, funct;
  logic [4:0]  shamt;
  logic [15:0] imm16;
  logic [4:0]  rs_idx, rt_idx, rd_idx, fwd1_rd, fwd2_rd, dst_idx;
  logic [31:0] rs_data, rt_data, fwd1_data, fwd2_data;
  logic        fwd1_we, fwd2_we;
  logic [1:0]  ALUCtl_2;
  logic [31:0] alu_a, alu_b, store_data;
  logic        reg_we, mem_rd, mem_wr, illegal;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .shamt(shamt), .imm16(imm16),
    .rs_idx(rs_idx), .rt_idx(rt_idx), .rd_idx(rd_idx), .rs_data(rs_data), .rt_data(rt_data),
    .fwd1_we(fwd1_we), .fwd1_rd(fwd1_rd), .fwd1_data(fwd1_data),
    .fwd2_we(fwd2_we), .fwd2_rd(fwd2_rd), .fwd2_data(fwd2_data),
    .out_valid(out_valid), .out_ready(out_ready), .ALUCtl_2(ALUCtl_2),
    .alu_a(alu_a), .alu_b(alu_b), .store_data(store_data), .dst_idx(dst_idx),
    .reg_we(reg_we), .mem_rd(mem_rd), .mem_wr(mem_wr), .illegal(illegal)
  );

  // expected EX-side view; c_* mark which fields the behaviour actually defines
  typedef struct {
    logic        valid;
    logic [1:0]  ctl;
    logic [31:0] a, b, sd;
    logic [4:0]  dst;
    logic        we, mrd, mwr, ill;
    logic        c_flags, c_ctl, c_a, c_b, c_dst, c_sd;
  } exp_t;

  exp_t e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t blank();
    exp_t r;
    r.valid = 0; r.ctl = 0; r.a = 0; r.b = 0; r.sd = 0; r.dst = 0;
    r.we = 0; r.mrd = 0; r.mwr = 0; r.ill = 0;
    r.c_flags = 0; r.c_ctl = 0; r.c_a = 0; r.c_b = 0; r.c_dst = 0; r.c_sd = 0;
    return r;
  endfunction

  function automatic logic [31:0] fwd_val(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 0) return 32'd0;
    if (fwd1_we && fwd1_rd == idx) return fwd1_data;
    if (fwd2_we && fwd2_rd == idx) return fwd2_data;
    return rf;
  endfunction

  function automatic exp_t decode();
    exp_t r;
    logic [31:0] vs, vt, sx;
    vs = fwd_val(rs_idx, rs_data);
    vt = fwd_val(rt_idx, rt_data);
    sx = {{16{imm16[15]}}, imm16};
    r = blank();
    r.valid = 1; r.c_flags = 1; r.c_ctl = 1;
    if (opcode == 6'h00 && (funct == 6'h20 || funct == 6'h22)) begin
      r.ctl = (funct == 6'h20) ? 2'd0 : 2'd1;
      r.a = vs; r.b = vt; r.dst = rd_idx; r.we = 1;
      r.c_a = 1; r.c_b = 1; r.c_dst = 1;
    end else if (opcode == 6'h00 && (funct == 6'h00 || funct == 6'h03)) begin
      r.ctl = (funct == 6'h00) ? 2'd2 : 2'd3;
      r.a = vt; r.b = {27'd0, shamt}; r.dst = rd_idx; r.we = 1;
      r.c_a = 1; r.c_b = 1; r.c_dst = 1;
    end else if (opcode == 6'h08 || opcode == 6'h23) begin
      r.a = vs; r.b = sx; r.dst = rt_idx; r.we = 1; r.mrd = (opcode == 6'h23);
      r.c_a = 1; r.c_b = 1; r.c_dst = 1;
    end else if (opcode == 6'h2B) begin
      r.a = vs; r.b = sx; r.sd = vt; r.mwr = 1;
      r.c_a = 1; r.c_b = 1; r.c_sd = 1;
    end else if (opcode == 6'h04) begin
      r.ctl = 2'd1; r.a = vs; r.b = vt;
      r.c_a = 1; r.c_b = 1;
    end else begin
      r.ill = 1;
    end
    if (r.dst == 0) r.we = 0;
    return r;
  endfunction

  task automatic check_all();
    check("out_valid", out_valid, e.valid);
    if (e.c_flags) begin
      check("reg_we", reg_we, e.we);
      check("mem_rd", mem_rd, e.mrd);
      check("mem_wr", mem_wr, e.mwr);
      check("illegal", illegal, e.ill);
    end
    if (e.c_ctl) check("ALUCtl_2", ALUCtl_2, e.ctl);
    if (e.c_a)   check("alu_a", alu_a, e.a);
    if (e.c_b)   check("alu_b", alu_b, e.b);
    if (e.c_dst) check("dst_idx", dst_idx, e.dst);
    if (e.c_sd)  check("store_data", store_data, e.sd);
  endtask

  // advance one clock: predict from current inputs, then compare after the edge
  task automatic tick();
    exp_t nxt;
    #1;
    if (rst_n) check("in_ready", in_ready, !e.valid || out_ready);
    if (!rst_n) begin
      nxt = blank();
      nxt.c_flags = 1; nxt.c_ctl = 1; nxt.c_a = 1; nxt.c_b = 1; nxt.c_dst = 1; nxt.c_sd = 1;
    end else if (flush) begin
      nxt = blank();
      nxt.c_flags = 1;
    end else if (!e.valid || out_ready) begin
      if (in_valid) nxt = decode();
      else          nxt = blank();
    end else begin
      nxt = e;
    end
    @(posedge clk);
    e = nxt;
    @(negedge clk);
    check_all();
  endtask

  task automatic clear_inputs();
    flush = 0; in_valid = 0; out_ready = 1;
    opcode = 0; funct = 0; shamt = 0; imm16 = 0;
    rs_idx = 0; rt_idx = 0; rd_idx = 0; rs_data = 0; rt_data = 0;
    fwd1_we = 0; fwd1_rd = 0; fwd1_data = 0; fwd2_we = 0; fwd2_rd = 0; fwd2_data = 0;
  endtask

  logic [5:0] op_tab [8];
  logic [5:0] fn_tab [5];

  initial begin
    e = blank();
    clear_inputs();
    rst_n = 0; in_valid = 1; opcode = 6'h08; rs_idx = 1; rt_idx = 2; imm16 = 16'h1234;
    tick(); tick();
    check("rst_in_ready", in_ready, 1'b1);
    rst_n = 1;
    clear_inputs();

    // add r3 = r1(5) + r2(7)
    in_valid = 1; opcode = 6'h00; funct = 6'h20; rs_idx = 1; rs_data = 5;
    rt_idx = 2; rt_data = 7; rd_idx = 3;
    tick();
    check("add_a", alu_a, 32'd5);
    check("add_b", alu_b, 32'd7);

    // addi with both forwards hitting rs: EX/MEM wins
    opcode = 6'h08; rs_idx = 4; rs_data = 32'h99; rt_idx = 6; imm16 = 16'hFFFF;
    fwd1_we = 1; fwd1_rd = 4; fwd1_data = 32'h10; fwd2_we = 1; fwd2_rd = 4; fwd2_data = 32'h20;
    tick();
    check("addi_a", alu_a, 32'h10);
    check("addi_b", alu_b, 32'hFFFF_FFFF);
    fwd1_we = 0; fwd2_we = 0;

    opcode = 6'h00; funct = 6'h03; rt_idx = 5; rt_data = 32'h8000_0000; shamt = 4; rd_idx = 7;
    tick();
    check("sra_ctl", ALUCtl_2, 2'd3);
    check("sra_b", alu_b, 32'd4);
    funct = 6'h00; shamt = 0;
    tick();
    check("sll_ctl", ALUCtl_2, 2'd2);
    check("sll_b", alu_b, 32'd0);

    // backpressure: hold for 3 cycles, then the waiting add appears one cycle after release
    out_ready = 0; funct = 6'h20; rs_idx = 1; rs_data = 32'h111; rt_idx = 2; rt_data = 32'h222; rd_idx = 9;
    tick(); tick(); tick();
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_hold_ctl", ALUCtl_2, 2'd2);
    out_ready = 1;
    tick();
    check("bp_new_a", alu_a, 32'h111);

    // flush beats the lw being accepted
    flush = 1; opcode = 6'h23; rs_idx = 1; rt_idx = 8; imm16 = 16'h0004;
    tick();
    check("flush_valid", out_valid, 1'b0);
    check("flush_mem_rd", mem_rd, 1'b0);
    flush = 0;

    opcode = 6'h3F;
    tick();
    check("ill_flag", illegal, 1'b1);
    check("ill_we", reg_we, 1'b0);
    in_valid = 0;
    tick();

    op_tab = '{6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h3F, 6'h11};
    fn_tab = '{6'h20, 6'h22, 6'h00, 6'h03, 6'h2A};
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      opcode    = op_tab[$urandom_range(0, 7)];
      funct     = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 4)];
      shamt     = 5'($urandom);
      imm16     = 16'($urandom);
      rs_idx    = 5'($urandom_range(0, 7));
      rt_idx    = 5'($urandom_range(0, 7));
      rd_idx    = 5'($urandom_range(0, 7));
      rs_data   = $urandom; rt_data = $urandom;
      fwd1_we   = 1'($urandom); fwd1_rd = 5'($urandom_range(0, 7)); fwd1_data = $urandom;
      fwd2_we   = 1'($urandom); fwd2_rd = 5'($urandom_range(0, 7)); fwd2_data = $urandom;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
